// File: rtl/if_pkg.sv
// Shared types and helpers for the LEGv8 instruction-fetch queue.
// Fetch entries carry a PC sized by N_DEFAULT; narrower PCs are zero-extended into it.
package if_pkg;

  localparam int INSTR_W   = 32;
  localparam int N_DEFAULT = 64;
  localparam logic [N_DEFAULT-1:0] PC_INC = 64'd4;

  typedef struct packed {
    logic [N_DEFAULT-1:0] pc;
    logic [INSTR_W-1:0]   instr;
  } fetch_entry_t;

  // Sequential fetch address; the add wraps silently at the top of the address space
  function automatic logic [N_DEFAULT-1:0] next_pc(input logic [N_DEFAULT-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Small first-word-fall-through FIFO of fetch entries.
// Flush has priority over push and pop; a full FIFO still accepts a push when popping.
module if_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  fetch_entry_t             i_wdata,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = 1;
  localparam logic [PTR_W:0]   COUNT_ONE  = 1;
  localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W+1)'(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W:0]   r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == COUNT_FULL);
  assign o_count  = r_count;
  assign o_head   = r_mem[r_rdPtr];
  assign w_doPop  = i_pop & ~o_empty & ~i_flush;
  assign w_doPush = i_push & ~i_flush & (~o_full | w_doPop);

  // Pointer and occupancy bookkeeping; flush returns everything to the empty state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + COUNT_ONE;
        2'b01:   r_count <= r_count - COUNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_wdata;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// LEGv8 fetch stage: PC register, instruction-memory address, and a buffered
// valid/ready hand-off of {pc, instr} pairs to decode. A taken branch reloads the PC
// and flushes the buffer. Optional performance counters are enabled by IF_PERF_CNT_EN.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int           N        = 64,
  parameter int           DEPTH    = 2,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [N-1:0]       imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [N-1:0]       redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [N-1:0]       dec_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  logic [N-1:0]          r_pc;
  logic [N-1:0]          w_redirectTarget;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_empty;
  logic                  w_full;
  logic [$clog2(DEPTH):0] w_count;
  fetch_entry_t          w_entry;
  fetch_entry_t          w_head;

  assign imem_addr        = r_pc;
  assign w_redirectTarget = redirect_pc & ~{{(N-2){1'b0}}, 2'b11};
  assign dec_valid        = ~w_empty;
  assign w_pop            = dec_valid & dec_ready;
  assign w_push           = ~redirect_valid & (~w_full | w_pop);
  assign w_entry.pc       = N_DEFAULT'(r_pc);
  assign w_entry.instr    = imem_data;
  assign dec_instr        = dec_valid ? w_head.instr : '0;
  assign dec_pc           = dec_valid ? N'(w_head.pc) : '0;

  // Program counter: redirect wins, otherwise advance on every accepted fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= w_redirectTarget;
    else if (w_push)         r_pc <= N'(next_pc(N_DEFAULT'(r_pc)));
  end

  if_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata (w_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetchCnt;
  logic [31:0] r_flushCnt;
  logic        w_flushHit;

  assign w_flushHit = redirect_valid & (w_count != '0);
  assign fetch_cnt  = r_fetchCnt;
  assign flush_cnt  = r_flushCnt;

  // Saturating counts of fetches and of redirects that threw away queued work
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetchCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_push && (r_fetchCnt != 32'hFFFF_FFFF))     r_fetchCnt <= r_fetchCnt + 32'd1;
      if (w_flushHit && (r_flushCnt != 32'hFFFF_FFFF)) r_flushCnt <= r_flushCnt + 32'd1;
    end
  end
`endif

endmodule
